// File: rtl/layer_out_collector.sv
// layer_out_collector
// Gathers one activation per neuron lane from a producing layer, then streams
// the whole layer out as serial words, one beat per accepted handshake.
//
// Optional feature (macro COLLECT_ARGMAX_EN): adds argmax_idx / argmax_valid,
// reporting the lane holding the largest unsigned activation of each streamed
// frame (lowest lane index wins ties).
//
// State table
//   IDLE    | no lane captured yet, waiting for the first in_valid
//   COLLECT | some lanes captured, waiting for the remaining ones
//   STREAM  | all lanes held, presenting buffer[idx] on out_data

module layer_out_collector #(
    parameter int numNeuron = 16,
    parameter int inWidth   = 8,
    parameter int outWidth  = 16,
    localparam int IdxW     = (numNeuron > 1) ? $clog2(numNeuron) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [numNeuron*inWidth-1:0]  in_data,
    input  logic [numNeuron-1:0]          in_valid,
    output logic [outWidth-1:0]           out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          busy,
`ifdef COLLECT_ARGMAX_EN
    output logic [IdxW-1:0]               argmax_idx,
    output logic                          argmax_valid,
`endif
    output logic                          overflow
);

    // Bits of a lane that survive into the output word: zero-extend when the
    // output is wider, keep only the LSBs when it is narrower.
    localparam int CopyW = (inWidth < outWidth) ? inWidth : outWidth;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        STREAM  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [inWidth-1:0]   buffer [numNeuron];
    logic [numNeuron-1:0] flags;
    logic [IdxW-1:0]      idx;

    logic                 collecting;
    logic                 all_flags;
    logic                 last_idx;
    logic                 beat_accept;
    logic                 frame_done;
    logic [inWidth-1:0]   cur_lane;
    logic [outWidth-1:0]  beat_word;

    assign collecting  = (state != STREAM);
    // Includes lanes arriving this cycle so the frame can close on the
    // capture edge of its last lane.
    assign all_flags   = &(flags | in_valid);
    assign last_idx    = (idx == IdxW'(numNeuron - 1));
    assign beat_accept = out_valid & out_ready;
    assign frame_done  = beat_accept & last_idx;
    assign cur_lane    = buffer[idx];

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|in_valid) begin
                    state_nxt = all_flags ? STREAM : COLLECT;
                end
            end
            COLLECT: begin
                if (all_flags) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (frame_done) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output word formatting from the lane selected by idx
    always_comb begin
        beat_word = '0;
        beat_word[CopyW-1:0] = cur_lane[CopyW-1:0];
    end

    // Stream-side outputs; out_data is forced to zero outside STREAM so a
    // reset or idle period never shows stale lane contents.
    always_comb begin
        out_valid = (state == STREAM);
        out_last  = out_valid & last_idx;
        busy      = (state != IDLE);
        out_data  = out_valid ? beat_word : '0;
    end

    // Lane capture storage; contents are meaningless until the flag is set,
    // so no reset is needed here.
    always_ff @(posedge clk) begin
        for (int k = 0; k < numNeuron; k++) begin
            if (collecting && in_valid[k]) begin
                buffer[k] <= in_data[k*inWidth +: inWidth];
            end
        end
    end

    // Lane flags, stream index and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags    <= '0;
            idx      <= '0;
            overflow <= 1'b0;
        end else if (collecting) begin
            flags <= flags | in_valid;
            // A lane pulsed twice before streaming overwrites its slot.
            if (|(flags & in_valid)) begin
                overflow <= 1'b1;
            end
        end else begin
            // Activations arriving while streaming are dropped.
            if (|in_valid) begin
                overflow <= 1'b1;
            end
            if (beat_accept) begin
                if (last_idx) begin
                    idx   <= '0;
                    flags <= '0;
                end else begin
                    idx <= idx + IdxW'(1);
                end
            end
        end
    end

`ifdef COLLECT_ARGMAX_EN
    logic [inWidth-1:0] max_val;
    logic [IdxW-1:0]    max_idx;
    logic               take_cur;

    // Beat 0 always seeds the running maximum; strict compare keeps the
    // earliest lane on ties.
    assign take_cur = (idx == '0) || (cur_lane > max_val);

    // Running maximum over accepted beats, published once per frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val      <= '0;
            max_idx      <= '0;
            argmax_idx   <= '0;
            argmax_valid <= 1'b0;
        end else begin
            argmax_valid <= 1'b0;
            if (beat_accept) begin
                if (take_cur) begin
                    max_val <= cur_lane;
                    max_idx <= idx;
                end
                if (last_idx) begin
                    argmax_idx   <= take_cur ? idx : max_idx;
                    argmax_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_layer_out_collector.sv
// Directed bench for layer_out_collector (16 lanes x 8 bits, 16-bit output).
module tb_layer_out_collector;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [127:0]  in_data = '0;
    logic [15:0]   in_valid = '0;
    logic [15:0]   out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          busy;
    logic          overflow;
`ifdef COLLECT_ARGMAX_EN
    logic [3:0]    argmax_idx;
    logic          argmax_valid;
`endif

    int            n_err = 0;
    int            n_chk = 0;
    logic [7:0]    lane_val [16];

    always #5 clk = ~clk;

    layer_out_collector #(
        .numNeuron(16),
        .inWidth(8),
        .outWidth(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .busy(busy),
`ifdef COLLECT_ARGMAX_EN
        .argmax_idx(argmax_idx),
        .argmax_valid(argmax_valid),
`endif
        .overflow(overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ramp(input logic [7:0] base);
        for (int k = 0; k < 16; k++) lane_val[k] = base + 8'(k);
    endtask

    // Present the selected lanes for one cycle, starting at a falling edge.
    task automatic apply(input logic [15:0] mask);
        @(negedge clk);
        in_valid = mask;
        for (int k = 0; k < 16; k++)
            if (mask[k]) in_data[k*8 +: 8] = lane_val[k];
    endtask

    // Expect a full frame built from lane_val. stall_mask bit c drops
    // out_ready in cycle c; lane 5 is pulsed with 0xAA in cycle intrude.
    task automatic stream_check(input string tag, input logic [15:0] stall_mask, input int intrude);
        int b = 0;
        int c = 0;
        while (b < 16 && c < 64) begin
            @(negedge clk);
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_data"}, 32'(out_data), {24'h0, lane_val[b]});
            chk({tag, "_last"}, 32'(out_last), 32'(b == 15));
            out_ready = (c < 16) ? ~stall_mask[c] : 1'b1;
            if (c == intrude) begin
                in_valid = 16'h0020;
                in_data[5*8 +: 8] = 8'hAA;
            end else begin
                in_valid = '0;
            end
            if (out_ready) b++;
            c++;
        end
        chk({tag, "_beats"}, 32'(b), 32'd16);
        out_ready = 1'b1;
        in_valid  = '0;
    endtask

    initial begin
        // reset values while rst is held
        #2;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // all lanes in one cycle, values 1..16
        set_ramp(8'h01);
        apply(16'hFFFF);
        stream_check("ramp", 16'h0000, -1);
        @(negedge clk);
        chk("ramp_busy_after", 32'(busy), 32'd0);
        chk("ramp_valid_after", 32'(out_valid), 32'd0);
        chk("ramp_ovf", 32'(overflow), 32'd0);

        // staggered arrival, one lane per cycle
        set_ramp(8'h40);
        for (int k = 0; k < 16; k++) begin
            apply(16'(1) << k);
            chk("stag_busy", 32'(busy), 32'(k != 0));
            chk("stag_valid", 32'(out_valid), 32'd0);
        end
        stream_check("stag", 16'h0000, -1);

        // back-pressure 1,0,0,1 with a dropped lane pulse during a stall
        set_ramp(8'h20);
        apply(16'hFFFF);
        stream_check("stall", 16'b0110, 1);
        @(negedge clk);
        chk("stall_ovf", 32'(overflow), 32'd1);
        chk("stall_busy_after", 32'(busy), 32'd0);

        // reset after 8 beats abandons the frame
        set_ramp(8'h60);
        apply(16'hFFFF);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            in_valid = '0;
            chk("pre_rst_data", 32'(out_data), {24'h0, lane_val[b]});
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ovf", 32'(overflow), 32'd0);
        chk("midrst_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(out_valid), 32'd0);
        end
        set_ramp(8'h80);
        apply(16'hFFFF);
        stream_check("after_rst", 16'h0000, -1);

        // lane 3 pulsed twice before the frame completes
        set_ramp(8'h01);
        lane_val[3] = 8'h11;
        apply(16'h0008);
        lane_val[3] = 8'h22;
        apply(16'h0008);
        chk("dup_ovf_pre", 32'(overflow), 32'd0);
        apply(16'hFFF7);
        chk("dup_ovf", 32'(overflow), 32'd1);
        stream_check("dup", 16'h0000, -1);
        @(negedge clk);
        chk("dup_ovf_sticky", 32'(overflow), 32'd1);

`ifdef COLLECT_ARGMAX_EN
        // tie between lanes 5 and 9 at the maximum
        set_ramp(8'h01);
        lane_val[5] = 8'hF0;
        lane_val[9] = 8'hF0;
        apply(16'hFFFF);
        stream_check("amax", 16'h0000, -1);
        @(negedge clk);
        chk("amax_valid", 32'(argmax_valid), 32'd1);
        chk("amax_idx", 32'(argmax_idx), 32'd5);
        @(negedge clk);
        chk("amax_valid_pulse", 32'(argmax_valid), 32'd0);
        chk("amax_idx_hold", 32'(argmax_idx), 32'd5);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/layer_out_collector.md
LAYER_OUT_COLLECTOR -- requirements
Module: layer_out_collector

Interface
REQ-001 Parameter numNeuron, default 16, number of neurons in the producing layer.
REQ-002 Parameter inWidth, default 8, width of each neuron activation output.
REQ-003 Parameter outWidth, default 16, width of the serial output word fed to the next layer's myinput.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_data  input  numNeuron*inWidth  packed neuron outputs; lane k at bits [k*inWidth +: inWidth].
REQ-007 in_valid  input  numNeuron  per-lane outvalid pulses.
REQ-008 out_data  output  outWidth  serial activation word.
REQ-009 out_valid  output  1  out_data holds a valid beat.
REQ-010 out_ready  input  1  downstream accepts a beat when out_valid & out_ready.
REQ-011 out_last  output  1  high on the beat carrying lane numNeuron-1.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 overflow  output  1  sticky error flag.

Function
REQ-014 FSM states: IDLE, COLLECT, STREAM.
REQ-015 In IDLE or COLLECT, a cycle with in_valid[k]=1 shall register lane k into buffer[k] and set flag[k]; multiple lanes may capture in one cycle.
REQ-016 IDLE->COLLECT on any in_valid bit; COLLECT->STREAM in the cycle after all flags are set (IDLE->STREAM directly if all in_valid bits arrive in one cycle).
REQ-017 A lane whose flag is already set, re-pulsed before STREAM, shall overwrite buffer[k] and set overflow.
REQ-018 In STREAM, out_valid=1 and out_data=buffer[idx] zero-extended to outWidth (truncated to the LSBs if inWidth>outWidth); idx starts at 0.
REQ-019 idx shall advance only on out_valid & out_ready; out_data shall be held stable while out_ready=0.
REQ-020 out_last = out_valid & (idx==numNeuron-1); acceptance of that beat shall clear all flags and idx and return to IDLE the next cycle.
REQ-021 Any in_valid bit during STREAM shall be dropped and shall set overflow.
REQ-022 Latency: the first beat appears 1 cycle after the capture cycle of the last lane; the throughput is one beat per cycle with out_ready held high.
REQ-023 overflow shall clear only on rst.

Reset
REQ-024 rst shall immediately force: state IDLE, idx 0, all flags 0, out_valid 0, out_last 0, busy 0, overflow 0, out_data 0; buffer contents are don't-care.
REQ-025 rst asserted mid-COLLECT or mid-STREAM shall abandon the frame; no partial beats shall follow deassertion.

Configuration
REQ-026 Macro COLLECT_ARGMAX_EN: when defined, outputs argmax_idx ($clog2(numNeuron) bits, reset 0) and argmax_valid (1 bit, reset 0) shall be added.
REQ-027 When COLLECT_ARGMAX_EN is defined, a running unsigned maximum shall be tracked during STREAM beat acceptance (the lowest index wins ties); argmax_valid shall pulse for one cycle after the out_last beat is accepted, with argmax_idx stable until the next pulse.
REQ-028 When COLLECT_ARGMAX_EN is undefined, those ports and that logic shall be absent, and all other behaviour shall be identical.

Verification
REQ-029 All 16 in_valid bits set in one cycle, lane k=k+1, out_ready=1 -> 16 beats 0x0001..0x0010 on consecutive cycles, out_last on the 16th beat, then busy=0.
REQ-030 Lanes arriving staggered one per cycle over 16 cycles -> the first beat appears 1 cycle after lane 15 is captured, with order and values unchanged.
REQ-031 out_ready toggled 1,0,0,1 during STREAM -> no beat lost or duplicated; out_data held during the stalls.
REQ-032 Lane 3 pulsed twice in COLLECT (0x11 then 0x22) -> beat 3 = 0x0022, overflow=1 and remaining high.
REQ-033 rst pulsed after 8 beats -> out_valid=0 immediately; a new full frame then streams from lane 0.
REQ-034 With COLLECT_ARGMAX_EN defined and lanes 5 and 9 both 0xF0 (maximum) -> argmax_idx=5, with one argmax_valid pulse.
